sound_scheduler: RTL and testbench
==================================

// Module: sound_scheduler
// PURPOSE
//  Arbitrates game-event sound requests (chomp, ghost eaten, death, start jingle) onto the single
//  audio engine. Latches requests, selects by fixed priority, holds the chosen sound_type for its
//  table duration in 8 kHz ticks, inserts a silent gap, then serves the next pending request.
//  Sits between drawing_logic game events and the audio block's sound_type input.
// PARAMETERS
//  N_REQ      4   number of requesters; requester i maps to sound_t value i+1
//  GAP_TICKS  80  silent 8 kHz ticks between consecutive sounds (10 ms); 0 = back-to-back
//  CNT_W      16  duration/gap counter width; must hold max(params::sound::DURATION) and GAP_TICKS
// PORTS
//  clk_25MHZ    in   1      pixel/system clock; one clock; reset is asynchronous and active-low
//  CPU_RESETN   in   1      async active-low reset
//  strobe_8khz  in   1      one-cycle tick from audio, 8 kHz rate
//  mute         in   1      1 = flush all pending and force silence
//  req          in   N_REQ  one-cycle request pulses; higher index = higher priority
//  grant        out  N_REQ  one-hot, one-cycle pulse when a request starts playing
//  sound_type   out  sound_t  sound currently driven to audio (SOUND_NONE when silent)
//  busy         out  1      1 in PLAY or GAP
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, cnt=0, sound_type=SOUND_NONE, grant=0, busy=0. All outputs registered.
//  - pending[i] set on req[i]; cleared on grant[i] or mute. req while already pending is absorbed.
//  - FSM IDLE: if (pending|req)!=0 and !mute -> PLAY with highest set index w; grant[w]=1;
//    sound_type=w+1; cnt=DURATION[w]-1. Latency: req at cycle t -> sound_type valid at t+1.
//  - PLAY: cnt decrements on strobe_8khz only. strobe with cnt==0 -> GAP (cnt=GAP_TICKS-1,
//    sound_type=NONE) or, if GAP_TICKS==0, directly to next selection as in IDLE (else IDLE).
//    Duration is exactly DURATION[w] strobes.
//  - Preemption: in PLAY, request/pending at index > current index -> restart PLAY next cycle with
//    that index (new grant pulse, fresh cnt); preempted sound is dropped, not re-queued.
//  - Retrigger: req equal to current index while PLAY sets pending (replays after gap), no restart.
//  - GAP: cnt decrements on strobe; strobe with cnt==0 -> selection as in IDLE. Higher-priority req
//    during GAP waits for the gap to finish (no preemption in GAP).
//  - Simultaneous: req arriving in the same cycle as the end condition is included in selection.
//    Multiple req bits same cycle: highest wins, others stay pending.
//  - mute: any state -> IDLE next cycle, sound_type=NONE, pending cleared, req ignored while high.
//  - DURATION entry 0 treated as 1. cnt never underflows; cnt changes only on strobe or load.
//  - Reset mid-PLAY: asynchronous return to reset values; no grant pulse emitted.
// STRUCTURE
//  - params::sound package: sound_t enum (SOUND_NONE=0, CHOMP, EAT_GHOST, DEATH, START),
//    DURATION[N_REQ] table in 8 kHz ticks, SOUND_STATE_W, state enum {IDLE, PLAY, GAP}.
//  - sound_t stays in common_defines.svh-visible scope so audio and this block share it.
//  - One sub-module: prio_pick (combinational highest-index-set picker, outputs index + valid).
//  - Top instantiates after drawing_logic; drives audio.sound_type; simulation build includes it
//    even though audio is excluded in Verilator.
// TESTING
//  1 Reset: CPU_RESETN low mid-PLAY -> sound_type=NONE, busy=0, grant=0 same edge, pending cleared.
//  2 Single: req=4'b0001 at t -> grant=0001 at t+1, sound_type=CHOMP for exactly DURATION[0]
//    strobes, then NONE for GAP_TICKS strobes, busy falls at gap end.
//  3 Priority: req=4'b0101 same cycle -> DEATH(3) plays first; CHOMP plays after DEATH+gap.
//  4 Preempt: CHOMP playing, req[3] pulse -> next cycle sound_type=START, grant=1000, CHOMP lost.
//  5 Boundary: req[1] coincident with final strobe of GAP -> EAT_GHOST starts next cycle;
//    GAP_TICKS=0 build -> no NONE cycle between sounds.
//  6 Mute: mute=1 with 3 pending during PLAY -> IDLE/NONE next cycle, pending=0; mute=0 -> stays idle.

Source files
------------

// File: rtl/sound_scheduler_pkg.sv
// Shared sound identifiers, duration table and state encoding for the sound scheduler.
// sound_t is also consumed by the audio block, so it lives here rather than in the scheduler.
package sound_scheduler_pkg;

    localparam int SOUND_W       = 3;
    localparam int N_SOUNDS      = 4;
    localparam int SOUND_STATE_W = 2;

    typedef enum logic [SOUND_W-1:0] {
        SOUND_NONE = 3'd0,
        CHOMP      = 3'd1,
        EAT_GHOST  = 3'd2,
        DEATH      = 3'd3,
        START      = 3'd4
    } sound_t;

    typedef enum logic [SOUND_STATE_W-1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Play lengths in 8 kHz ticks, indexed by requester (sound_t value minus one).
    localparam int unsigned DURATION [N_SOUNDS] = '{800, 2400, 12000, 33600};

    // Counter preload for a sound; a zero-length entry still plays for one tick.
    function automatic int unsigned dur_load(input int unsigned ticks);
        return (ticks == 32'd0) ? 32'd0 : ticks - 32'd1;
    endfunction

    function automatic sound_t idx_to_sound(input int unsigned idx);
        return sound_t'(SOUND_W'(idx + 32'd1));
    endfunction

endpackage

// File: rtl/sound_scheduler_prio_pick.sv
// Combinational fixed-priority picker: reports the highest set index of cand and whether any bit is set.
module sound_scheduler_prio_pick
    import sound_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     cand,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        // Ascending scan so the highest set index is the one left standing.
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates game-event sound requests onto the single audio engine: latch, pick by fixed
// priority, play for the table duration in 8 kHz ticks, insert a silent gap, serve the next.
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter int          N_REQ            = 4,
    parameter int          GAP_TICKS        = 80,
    parameter int          CNT_W            = 16,
    parameter int unsigned DUR_TAB [N_REQ]  = DURATION
) (
    input  logic             clk_25MHZ,
    input  logic             CPU_RESETN,
    input  logic             strobe_8khz,
    input  logic             mute,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output sound_t           sound_type,
    output logic             busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_TICKS == 0) ? '0 : CNT_W'(GAP_TICKS - 1);

    state_t             state;
    state_t             state_next;
    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   pending_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   cur_next;
    logic [N_REQ-1:0]   grant_next;
    sound_t             sound_next;
    logic               busy_next;

    logic [N_REQ-1:0]   cand;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [N_REQ-1:0]   sel_mask;
    logic               tick_end;
    logic               load;

    // Mute blanks both fresh requests and the latched backlog.
    assign cand     = mute ? '0 : (pending | req);
    assign sel_mask = N_REQ'(1) << pick_idx;
    assign tick_end = strobe_8khz && (cnt == '0);

    sound_scheduler_prio_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand (cand),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    always_ff @(posedge clk_25MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= IDLE;
            pending    <= '0;
            cnt        <= '0;
            cur        <= '0;
            grant      <= '0;
            sound_type <= SOUND_NONE;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            cnt        <= cnt_next;
            cur        <= cur_next;
            grant      <= grant_next;
            sound_type <= sound_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = PLAY;
                    load       = 1'b1;
                end
            end
            PLAY: begin
                if (mute) begin
                    state_next = IDLE;
                end else if (pick_vld && (pick_idx > cur)) begin
                    // Preemption restarts PLAY; the interrupted sound is simply dropped.
                    load = 1'b1;
                end else if (tick_end) begin
                    if (GAP_TICKS != 0) begin
                        state_next = GAP;
                    end else if (pick_vld) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (mute) begin
                    state_next = IDLE;
                end else if (tick_end) begin
                    if (pick_vld) begin
                        state_next = PLAY;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next = cand;
        cnt_next     = cnt;
        cur_next     = cur;
        grant_next   = '0;
        sound_next   = sound_type;
        busy_next    = (state_next != IDLE);
        if (load) begin
            pending_next = cand & ~sel_mask;
            cnt_next     = CNT_W'(dur_load(DUR_TAB[pick_idx]));
            cur_next     = pick_idx;
            grant_next   = sel_mask;
            sound_next   = idx_to_sound(32'(pick_idx));
        end else if ((state_next == GAP) && (state != GAP)) begin
            cnt_next   = GAP_LOAD;
            sound_next = SOUND_NONE;
        end else if (state_next == IDLE) begin
            sound_next = SOUND_NONE;
        end else if (strobe_8khz && (cnt != '0)) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: a gapped build and a back-to-back build, with an event
// scoreboard that compares every grant pulse and every sound_type/busy change against a timed queue.
module tb_sound_scheduler;
    import sound_scheduler_pkg::*;

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] grant;
        sound_t     st;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic       strobe_a = 1'b0, strobe_b = 1'b0;
    logic       mute_a = 1'b0, mute_b = 1'b0;
    logic [3:0] grant_a, grant_b;
    sound_t     st_a, st_b;
    logic       busy_a, busy_b;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    ev_t   exp_q[$];
    string name_q[$];

    sound_t prev_st_a = SOUND_NONE, prev_st_b = SOUND_NONE;
    logic   prev_busy_a = 1'b0, prev_busy_b = 1'b0;

    // Table: CHOMP 3, EAT_GHOST 0 (plays as 1), DEATH 4, START 2 ticks.
    sound_scheduler #(
        .N_REQ(4), .GAP_TICKS(3), .CNT_W(8), .DUR_TAB('{3, 0, 4, 2})
    ) dut_a (
        .clk_25MHZ(clk), .CPU_RESETN(rst_n), .strobe_8khz(strobe_a), .mute(mute_a),
        .req(req_a), .grant(grant_a), .sound_type(st_a), .busy(busy_a)
    );

    sound_scheduler #(
        .N_REQ(4), .GAP_TICKS(0), .CNT_W(8), .DUR_TAB('{3, 0, 4, 2})
    ) dut_b (
        .clk_25MHZ(clk), .CPU_RESETN(rst_n), .strobe_8khz(strobe_b), .mute(mute_b),
        .req(req_b), .grant(grant_b), .sound_type(st_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input string nm, input int d, input int c, input logic [3:0] g,
                            input sound_t st, input logic b);
        ev_t e;
        e.dut = d; e.cyc = c; e.grant = g; e.st = st; e.busy = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic observe(input int d, input logic [3:0] g, input sound_t st, input logic b);
        ev_t   e;
        string nm;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: dut%0d cyc=%0d grant=%b sound=%0d busy=%b, required no event",
                     d, cyc, g, st, b);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.dut != d || e.cyc != cyc || e.grant != g || e.st != st || e.busy != b) begin
                n_fail++;
                $display("FAIL %s: got dut%0d cyc=%0d grant=%b sound=%0d busy=%b, required dut%0d cyc=%0d grant=%b sound=%0d busy=%b",
                         nm, d, cyc, g, st, b, e.dut, e.cyc, e.grant, e.st, e.busy);
            end
        end
    endtask

    always @(negedge clk) begin
        if (grant_a != 4'b0 || st_a != prev_st_a || busy_a != prev_busy_a) observe(0, grant_a, st_a, busy_a);
        if (grant_b != 4'b0 || st_b != prev_st_b || busy_b != prev_busy_b) observe(1, grant_b, st_b, busy_b);
        prev_st_a   <= st_a;
        prev_busy_a <= busy_a;
        prev_st_b   <= st_b;
        prev_busy_b <= busy_b;
    end

    task automatic drive(input int d, input logic [3:0] r, input logic s, input logic m);
        if (d == 0) begin
            req_a = r; strobe_a = s; mute_a = m;
        end else begin
            req_b = r; strobe_b = s; mute_b = m;
        end
        @(posedge clk);
        #1;
        req_a = '0; strobe_a = 1'b0; mute_a = 1'b0;
        req_b = '0; strobe_b = 1'b0; mute_b = 1'b0;
    endtask

    task automatic strobes(input int d, input int n);
        repeat (n) begin
            drive(d, 4'b0, 1'b1, 1'b0);
            drive(d, 4'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) drive(d, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, want);
        end
    endtask

    initial begin
        int    t0;
        ev_t   e;
        string nm;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", int'(grant_a), 0);
        chk("reset_sound", int'(st_a), int'(SOUND_NONE));
        chk("reset_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        idle(0, 2);

        // Single CHOMP: 3 ticks of sound, 3 ticks of gap.
        t0 = cyc;
        push_exp("single_grant", 0, t0 + 1, 4'b0001, CHOMP, 1'b1);
        push_exp("single_gap", 0, t0 + 6, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("single_idle", 0, t0 + 12, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        strobes(0, 3); strobes(0, 3); idle(0, 2);

        // Two requests together: DEATH first, CHOMP after DEATH and a gap.
        t0 = cyc;
        push_exp("prio_death", 0, t0 + 1, 4'b0100, DEATH, 1'b1);
        push_exp("prio_gap1", 0, t0 + 8, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("prio_chomp", 0, t0 + 14, 4'b0001, CHOMP, 1'b1);
        push_exp("prio_gap2", 0, t0 + 20, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("prio_idle", 0, t0 + 26, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0101, 1'b0, 1'b0);
        strobes(0, 4); strobes(0, 3); strobes(0, 3); strobes(0, 3); idle(0, 2);

        // START preempts a playing CHOMP; CHOMP is not replayed.
        t0 = cyc;
        push_exp("preempt_chomp", 0, t0 + 1, 4'b0001, CHOMP, 1'b1);
        push_exp("preempt_start", 0, t0 + 4, 4'b1000, START, 1'b1);
        push_exp("preempt_gap", 0, t0 + 7, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("preempt_idle", 0, t0 + 13, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        strobes(0, 1);
        drive(0, 4'b1000, 1'b0, 1'b0);
        strobes(0, 2); strobes(0, 3); idle(0, 2);

        // Retrigger of the playing sound replays it after the gap without a restart.
        t0 = cyc;
        push_exp("retrig_first", 0, t0 + 1, 4'b0001, CHOMP, 1'b1);
        push_exp("retrig_gap1", 0, t0 + 7, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("retrig_replay", 0, t0 + 13, 4'b0001, CHOMP, 1'b1);
        push_exp("retrig_gap2", 0, t0 + 19, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("retrig_idle", 0, t0 + 25, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        strobes(0, 3); strobes(0, 3); strobes(0, 3); strobes(0, 3); idle(0, 2);

        // EAT_GHOST requested on the last gap tick starts at once; zero duration plays one tick.
        t0 = cyc;
        push_exp("edge_chomp", 0, t0 + 1, 4'b0001, CHOMP, 1'b1);
        push_exp("edge_gap1", 0, t0 + 6, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("edge_ghost", 0, t0 + 12, 4'b0010, EAT_GHOST, 1'b1);
        push_exp("edge_gap2", 0, t0 + 13, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("edge_idle", 0, t0 + 19, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        strobes(0, 3); strobes(0, 2);
        drive(0, 4'b0010, 1'b1, 1'b0);
        strobes(0, 1); strobes(0, 3); idle(0, 2);

        // Higher priority arriving in GAP waits for the gap to finish.
        t0 = cyc;
        push_exp("gapwait_chomp", 0, t0 + 1, 4'b0001, CHOMP, 1'b1);
        push_exp("gapwait_gap1", 0, t0 + 6, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("gapwait_start", 0, t0 + 13, 4'b1000, START, 1'b1);
        push_exp("gapwait_gap2", 0, t0 + 17, 4'b0000, SOUND_NONE, 1'b1);
        push_exp("gapwait_idle", 0, t0 + 23, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0001, 1'b0, 1'b0);
        strobes(0, 3);
        drive(0, 4'b1000, 1'b0, 1'b0);
        strobes(0, 3); strobes(0, 2); strobes(0, 3); idle(0, 2);

        // Mute with three pending flushes everything; nothing plays once mute drops.
        t0 = cyc;
        push_exp("mute_start", 0, t0 + 1, 4'b1000, START, 1'b1);
        push_exp("mute_silence", 0, t0 + 3, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b1000, 1'b0, 1'b0);
        drive(0, 4'b0111, 1'b0, 1'b0);
        drive(0, 4'b0000, 1'b0, 1'b1);
        drive(0, 4'b0001, 1'b0, 1'b1);
        idle(0, 4); strobes(0, 4); idle(0, 2);

        // Asynchronous reset mid-PLAY clears outputs at once and drops the pending EAT_GHOST.
        t0 = cyc;
        push_exp("rst_death", 0, t0 + 1, 4'b0100, DEATH, 1'b1);
        push_exp("rst_clear", 0, t0 + 3, 4'b0000, SOUND_NONE, 1'b0);
        drive(0, 4'b0110, 1'b0, 1'b0);
        strobes(0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 3); strobes(0, 6); idle(0, 2);

        // Back-to-back build: CHOMP follows DEATH with no silent cycle.
        t0 = cyc;
        push_exp("b2b_death", 1, t0 + 1, 4'b0100, DEATH, 1'b1);
        push_exp("b2b_chomp", 1, t0 + 8, 4'b0001, CHOMP, 1'b1);
        push_exp("b2b_idle", 1, t0 + 14, 4'b0000, SOUND_NONE, 1'b0);
        drive(1, 4'b0101, 1'b0, 1'b0);
        strobes(1, 4); strobes(1, 3); idle(1, 20);

        while (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: event never seen, required dut%0d cyc=%0d grant=%b sound=%0d busy=%b",
                     nm, e.dut, e.cyc, e.grant, e.st, e.busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
